vga_pixel_gen: RTL and testbench

Pixel generator that sits directly downstream of the VGA timing generator on the 25 MHz pixel clock. Consumes the pixel coordinates, display-enable and sync strobes, and produces registered 4-bit-per-channel RGB plus matching delayed syncs for the DAC/connector pins. Draws a background colour, a one-pixel white frame around the 640x480 active area, and a solid rectangular robot marker. A small configuration write port updates the marker position and colours, with tear-free double-buffering at the vertical-blanking boundary.

---
 rtl/vga_pixel_gen_if.sv | 18 +
 rtl/vga_pixel_gen.sv | 147 ++++++++++++++
 tb/tb_vga_pixel_gen.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pixel_gen_if.sv
// Configuration write port for vga_pixel_gen.
// Master drives writes; the pixel generator reports pending shadow state.
interface vga_pixel_gen_if;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [11:0] cfg_data;
    logic        cfg_pending;

    modport master (
        output cfg_we, cfg_addr, cfg_data,
        input  cfg_pending
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data,
        output cfg_pending
    );
endinterface

// File: rtl/vga_pixel_gen.sv
// Two-stage VGA pixel generator: background, white frame and marker,
// with shadow/active config banks swapped on the first blanking line.
module vga_pixel_gen #(
    parameter int SPRITE_W = 32,
    parameter int SPRITE_H = 32,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clock25,
    input  logic        reset,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        display_on,
    input  logic        h_sync,
    input  logic        v_sync,
    vga_pixel_gen_if.slave cfg,
    output logic        frame_start,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        vga_hs,
    output logic        vga_vs
);

    localparam logic [9:0]  X_LAST  = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  Y_LAST  = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  Y_CMT   = 10'(V_ACTIVE);
    localparam logic [10:0] SW      = 11'(SPRITE_W);
    localparam logic [10:0] SH      = 11'(SPRITE_H);
    localparam logic [11:0] WHITE   = 12'hFFF;
    localparam logic [11:0] MC_RST  = 12'hF00;

    logic [11:0] bg_sh_q, bg_sh_d, mc_sh_q, mc_sh_d;
    logic [9:0]  mx_sh_q, mx_sh_d, my_sh_q, my_sh_d;
    logic [11:0] bg_q, mc_q;
    logic [9:0]  mx_q, my_q;
    logic        pend_q, pend_d, fs_q;
    logic        commit;

    logic [9:0]  x1_q, y1_q;
    logic        de1_q, hs1_q, vs1_q;
    logic [11:0] rgb_q, rgb_d;
    logic        hs2_q, vs2_q;

    logic [10:0] x11, y11, mx11, my11;
    logic        border, hit;

    assign commit = (pixel_x == 10'd0) && (pixel_y == Y_CMT);

    always_comb begin
        bg_sh_d = bg_sh_q;
        mx_sh_d = mx_sh_q;
        my_sh_d = my_sh_q;
        mc_sh_d = mc_sh_q;
        if (cfg.cfg_we) begin
            unique case (cfg.cfg_addr)
                2'd0: bg_sh_d = cfg.cfg_data;
                2'd1: mx_sh_d = cfg.cfg_data[9:0];
                2'd2: my_sh_d = cfg.cfg_data[9:0];
                2'd3: mc_sh_d = cfg.cfg_data;
            endcase
        end
        pend_d = cfg.cfg_we | (pend_q & ~commit);
    end

    // Active bank copies the pre-write shadow, so a same-cycle write waits a frame.
    always_ff @(posedge clock25) begin
        if (reset) begin
            bg_sh_q <= '0;
            mx_sh_q <= '0;
            my_sh_q <= '0;
            mc_sh_q <= MC_RST;
            bg_q    <= '0;
            mx_q    <= '0;
            my_q    <= '0;
            mc_q    <= MC_RST;
            pend_q  <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            bg_sh_q <= bg_sh_d;
            mx_sh_q <= mx_sh_d;
            my_sh_q <= my_sh_d;
            mc_sh_q <= mc_sh_d;
            pend_q  <= pend_d;
            fs_q    <= commit;
            if (commit) begin
                bg_q <= bg_sh_q;
                mx_q <= mx_sh_q;
                my_q <= my_sh_q;
                mc_q <= mc_sh_q;
            end
        end
    end

    always_ff @(posedge clock25) begin
        if (reset) begin
            x1_q  <= '0;
            y1_q  <= '0;
            de1_q <= 1'b0;
            hs1_q <= 1'b1;
            vs1_q <= 1'b1;
        end else begin
            x1_q  <= pixel_x;
            y1_q  <= pixel_y;
            de1_q <= display_on;
            hs1_q <= h_sync;
            vs1_q <= v_sync;
        end
    end

    // 11-bit compares keep an edge-hugging marker clipped instead of wrapping.
    always_comb begin
        x11    = {1'b0, x1_q};
        y11    = {1'b0, y1_q};
        mx11   = {1'b0, mx_q};
        my11   = {1'b0, my_q};
        border = (x1_q == 10'd0) || (x1_q == X_LAST) ||
                 (y1_q == 10'd0) || (y1_q == Y_LAST);
        hit    = (x11 >= mx11) && (x11 < mx11 + SW) &&
                 (y11 >= my11) && (y11 < my11 + SH);
        if (!de1_q)      rgb_d = '0;
        else if (border) rgb_d = WHITE;
        else if (hit)    rgb_d = mc_q;
        else             rgb_d = bg_q;
    end

    always_ff @(posedge clock25) begin
        if (reset) begin
            rgb_q <= '0;
            hs2_q <= 1'b1;
            vs2_q <= 1'b1;
        end else begin
            rgb_q <= rgb_d;
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
        end
    end

    assign cfg.cfg_pending = pend_q;
    assign frame_start     = fs_q;
    assign red             = rgb_q[11:8];
    assign green           = rgb_q[7:4];
    assign blue            = rgb_q[3:0];
    assign vga_hs          = hs2_q;
    assign vga_vs          = vs2_q;

endmodule

// File: tb/tb_vga_pixel_gen.sv
// Bench for vga_pixel_gen: behavioural frame model checked every cycle,
// a table of pixel/colour vectors, and hand-written commit corner cases.
module tb_vga_pixel_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] px, py;
    logic       de, hs, vs;
    logic       fs;
    logic [3:0] r, g, b;
    logic       ohs, ovs;
    int         errs = 0;
    int         checks = 0;

    vga_pixel_gen_if cif ();

    vga_pixel_gen dut (
        .clock25    (clk),
        .reset      (rst),
        .pixel_x    (px),
        .pixel_y    (py),
        .display_on (de),
        .h_sync     (hs),
        .v_sync     (vs),
        .cfg        (cif),
        .frame_start(fs),
        .red        (r),
        .green      (g),
        .blue       (b),
        .vga_hs     (ohs),
        .vga_vs     (ovs)
    );

    always #20 clk = ~clk;

    // Reference state: register banks as arrays, pipeline as plain values.
    int sh[4];
    int ac[4];
    bit m_pend, m_fs;
    int s1x, s1y;
    bit s1de, s1hs, s1vs;
    int m_rgb;
    bit m_hs, m_vs;

    typedef struct {
        int phase;
        int x;
        int y;
        bit de;
        int exp;
    } vec_t;

    vec_t tbl[$];

    function automatic int ref_colour(int x, int y, bit d);
        if (!d) return 0;
        if (x == 0 || x == 639 || y == 0 || y == 479) return 'hFFF;
        if (x >= ac[1] && x < ac[1] + 32 && y >= ac[2] && y < ac[2] + 32)
            return ac[3];
        return ac[0];
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic cyc(input int x, input int y, input bit d, input bit h,
                       input bit v, input bit we, input int addr,
                       input int data, input bit rs);
        int got, exp;
        rst = rs;
        px = 10'(x);
        py = 10'(y);
        de = d;
        hs = h;
        vs = v;
        cif.cfg_we = we;
        cif.cfg_addr = 2'(addr);
        cif.cfg_data = 12'(data);
        @(posedge clk);
        if (rs) begin
            sh = '{0, 0, 0, 'hF00};
            ac = '{0, 0, 0, 'hF00};
            m_pend = 0;
            m_fs = 0;
            s1x = 0; s1y = 0; s1de = 0; s1hs = 1; s1vs = 1;
            m_rgb = 0; m_hs = 1; m_vs = 1;
        end else begin
            m_rgb = ref_colour(s1x, s1y, s1de);
            m_hs = s1hs;
            m_vs = s1vs;
            s1x = x; s1y = y; s1de = d; s1hs = h; s1vs = v;
            m_fs = (x == 0 && y == 480);
            if (m_fs) ac = sh;
            if (we) sh[addr] = (addr == 1 || addr == 2) ? (data & 'h3FF) : data;
            m_pend = we ? 1'b1 : (m_fs ? 1'b0 : m_pend);
        end
        @(negedge clk);
        got = {16'd0, r, g, b, ohs, ovs, cif.cfg_pending, fs};
        exp = {16'd0, 12'(m_rgb), m_hs, m_vs, m_pend, m_fs};
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL cyc(%0d,%0d): got rgb/hs/vs/pend/fs %h expected %h",
                     x, y, got, exp);
        end
    endtask

    task automatic pix(input int x, input int y);
        cyc(x, y, x < 640 && y < 480, !(x >= 656 && x < 752),
            !(y >= 490 && y < 492), 0, 0, 0, 0);
    endtask

    task automatic wr(input int x, input int y, input int a, input int dt);
        cyc(x, y, x < 640 && y < 480, 1, 1, 1, a, dt, 0);
    endtask

    task automatic show(input string name, input int x, input int y,
                        input bit d, input int exp);
        cyc(x, y, d, 1, 1, 0, 0, 0, 0);
        cyc(x, y, d, 1, 1, 0, 0, 0, 0);
        chk(name, {20'd0, r, g, b}, exp);
    endtask

    initial begin
        tbl.push_back('{0, 100, 50, 1, 'h0F0});
        tbl.push_back('{0, 131, 81, 1, 'h0F0});
        tbl.push_back('{0, 99, 50, 1, 'h00F});
        tbl.push_back('{0, 132, 50, 1, 'h00F});
        tbl.push_back('{0, 100, 82, 1, 'h00F});
        tbl.push_back('{0, 100, 49, 1, 'h00F});
        tbl.push_back('{0, 0, 0, 1, 'hFFF});
        tbl.push_back('{0, 639, 479, 1, 'hFFF});
        tbl.push_back('{0, 115, 60, 0, 'h000});
        tbl.push_back('{1, 620, 470, 1, 'h0F0});
        tbl.push_back('{1, 638, 478, 1, 'h0F0});
        tbl.push_back('{1, 639, 470, 1, 'hFFF});
        tbl.push_back('{1, 620, 479, 1, 'hFFF});
        tbl.push_back('{1, 1, 470, 1, 'h00F});
        tbl.push_back('{1, 0, 470, 1, 'hFFF});
        tbl.push_back('{1, 619, 470, 1, 'h00F});
        tbl.push_back('{1, 630, 469, 1, 'h00F});
        tbl.push_back('{1, 640, 475, 0, 'h000});

        for (int i = 0; i < 3; i++) cyc(5, 5, 1, 1, 1, 0, 0, 0, 1);
        chk("reset_rgb", {20'd0, r, g, b}, 0);
        chk("reset_sync", {30'd0, ohs, ovs}, 3);
        chk("reset_pend", {31'd0, cif.cfg_pending}, 0);

        // Mid-line reset, then sync latency after release.
        for (int x = 200; x < 205; x++) pix(x, 10);
        wr(205, 10, 0, 'h555);
        for (int i = 0; i < 3; i++) begin
            cyc(206 + i, 10, 1, 1, 1, 0, 0, 0, 1);
            chk("midreset_out", {r, g, b, ohs, ovs, cif.cfg_pending}, 'h0006);
        end
        cyc(700, 10, 0, 0, 1, 0, 0, 0, 0);
        chk("hs_lat1", {31'd0, ohs}, 1);
        cyc(701, 10, 0, 0, 1, 0, 0, 0, 0);
        chk("hs_lat2", {31'd0, ohs}, 0);
        pix(0, 480);
        show("lost_write", 300, 300, 1, 'h000);

        // Deferred background write and a single frame_start pulse.
        wr(10, 20, 0, 'h222);
        pix(0, 480);
        wr(50, 100, 0, 'h00F);
        chk("pend_set", {31'd0, cif.cfg_pending}, 1);
        show("old_bg", 100, 200, 1, 'h222);
        begin
            int pulses = 0;
            for (int y = 478; y < 483; y++)
                for (int x = 0; x < 3; x++) begin
                    pix(x, y);
                    pulses += int'(fs);
                end
            chk("fs_count", pulses, 1);
        end
        chk("pend_clr", {31'd0, cif.cfg_pending}, 0);
        show("new_bg", 100, 100, 1, 'h00F);

        // Table vectors, each phase preceded by its marker configuration.
        for (int i = 0; i < tbl.size(); i++) begin
            if (i == 0 || tbl[i].phase != tbl[i-1].phase) begin
                if (tbl[i].phase == 0) begin
                    wr(300, 490, 1, 100);
                    wr(301, 490, 2, 'hC00 | 50);
                    wr(302, 490, 3, 'h0F0);
                end else begin
                    wr(300, 490, 1, 620);
                    wr(301, 490, 2, 470);
                end
                pix(0, 480);
            end
            show($sformatf("tbl%0d", i), tbl[i].x, tbl[i].y, tbl[i].de,
                 tbl[i].exp);
        end

        // Colour write landing on the commit cycle itself.
        wr(0, 480, 3, 'hABC);
        chk("cmtwr_fs", {31'd0, fs}, 1);
        chk("cmtwr_pend", {31'd0, cif.cfg_pending}, 1);
        show("cmtwr_old", 625, 475, 1, 'h0F0);
        pix(0, 480);
        show("cmtwr_new", 625, 475, 1, 'hABC);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int x, y, a, dt;
            bit w, rs;
            x = $urandom_range(0, 799);
            y = $urandom_range(0, 524);
            if ($urandom_range(0, 40) == 0) begin x = 0; y = 480; end
            w = ($urandom_range(0, 5) == 0);
            a = $urandom_range(0, 3);
            dt = $urandom_range(0, 4095);
            if (a == 1 || a == 2)
                dt = ($urandom_range(0, 3) << 10) | $urandom_range(0, 660);
            rs = ($urandom_range(0, 400) == 0);
            cyc(x, y, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                $urandom_range(0, 1), w, a, dt, rs);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
